// File: rtl/pkt_bank_scheduler.sv
// Packet BRAM bank scheduler: grants banks to the ingress writer and launches egress reads in commit order.
// Define PKT_SCHED_TIMEOUT_EN to add a start->finish watchdog on the backend.
module pkt_bank_scheduler #(
  parameter int NUM_BANKS   = 2,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 4096,
  localparam int BANK_W     = $clog2(NUM_BANKS)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              wr_req,
  output logic              wr_gnt,
  output logic [BANK_W-1:0] wr_bank,
  input  logic              wr_done,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              start,
  output logic [BANK_W-1:0] rd_bank,
  output logic [LEN_W-1:0]  length_be,
  input  logic              finish,
  output logic [2:0]        banks_free,
  output logic              err_proto,
  output logic              err_timeout
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY, B_DRAINING} bank_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LAUNCH, L_WAIT_FIN} launch_state_t;

  localparam logic [BANK_W:0] CNT_ONE = (BANK_W+1)'(1);

  bank_state_t       bank_q [NUM_BANKS];
  bank_state_t       bank_d [NUM_BANKS];
  logic [LEN_W-1:0]  len_q  [NUM_BANKS];
  logic [BANK_W-1:0] fifo_q [NUM_BANKS];
  logic [BANK_W-1:0] fifo_d [NUM_BANKS];
  logic [BANK_W:0]   cnt_q, cnt_d, cnt_pop;
  logic [BANK_W-1:0] rr_q, alloc_bank;
  logic [LEN_W-1:0]  head_len;
  logic              alloc_found, do_alloc, commit, push, pop, release_bank, expire;
  launch_state_t     fsm_q, fsm_d;

  // wr_gnt is high exactly while some bank is FILLING, so it doubles as the "no bank filling" test.
  assign do_alloc     = wr_req && !wr_gnt && alloc_found;
  assign commit       = wr_done && wr_gnt;
  assign push         = commit && (wr_len != '0);
  assign pop          = (fsm_q == L_IDLE) && (cnt_q != '0);
  assign release_bank = (fsm_q == L_WAIT_FIN) && (finish || expire);
  assign start        = (fsm_q == L_LAUNCH);
  assign err_timeout  = expire;

  always_comb begin
    alloc_found = 1'b0;
    alloc_bank  = '0;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      for (int j = 0; j < NUM_BANKS; j++) begin
        if (!alloc_found && j == (int'(rr_q) + i) % NUM_BANKS && bank_q[j] == B_FREE) begin
          alloc_found = 1'b1;
          alloc_bank  = BANK_W'(j);
        end
      end
    end
  end

  // Each transition leaves a distinct source state, so the updates never collide on one bank.
  always_comb begin
    head_len = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_d[i] = bank_q[i];
      if (fifo_q[0] == BANK_W'(i)) head_len = len_q[i];
      if (do_alloc && alloc_bank == BANK_W'(i)) bank_d[i] = B_FILLING;
      if (commit && wr_bank == BANK_W'(i)) bank_d[i] = push ? B_READY : B_FREE;
      if (pop && fifo_q[0] == BANK_W'(i)) bank_d[i] = B_DRAINING;
      if (release_bank && rd_bank == BANK_W'(i)) bank_d[i] = B_FREE;
    end
  end

  always_comb begin
    fifo_d  = fifo_q;
    cnt_pop = pop ? cnt_q - CNT_ONE : cnt_q;
    if (pop) begin
      for (int i = 0; i < NUM_BANKS - 1; i++) fifo_d[i] = fifo_q[i+1];
    end
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (push && cnt_pop == (BANK_W+1)'(i)) fifo_d[i] = wr_bank;
    end
    cnt_d = push ? cnt_pop + CNT_ONE : cnt_pop;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      L_IDLE:     if (pop) fsm_d = L_LAUNCH;
      L_LAUNCH:   fsm_d = L_WAIT_FIN;
      L_WAIT_FIN: if (finish || expire) fsm_d = L_IDLE;
      default:    fsm_d = L_IDLE;
    endcase
  end

  always_comb begin
    banks_free = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_q[i] == B_FREE) banks_free = banks_free + 3'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fsm_q     <= L_IDLE;
      cnt_q     <= '0;
      rr_q      <= BANK_W'(NUM_BANKS - 1);
      wr_gnt    <= 1'b0;
      wr_bank   <= '0;
      rd_bank   <= '0;
      length_be <= '0;
      err_proto <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= B_FREE;
        len_q[i]  <= '0;
        fifo_q[i] <= '0;
      end
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      err_proto <= (wr_done && !wr_gnt) || (finish && fsm_q != L_WAIT_FIN);
      if (do_alloc) begin
        wr_gnt  <= 1'b1;
        wr_bank <= alloc_bank;
        rr_q    <= alloc_bank;
      end else if (commit) begin
        wr_gnt <= 1'b0;
      end
      if (pop) begin
        rd_bank   <= fifo_q[0];
        length_be <= head_len;
      end
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= bank_d[i];
        fifo_q[i] <= fifo_d[i];
        if (commit && wr_bank == BANK_W'(i)) len_q[i] <= wr_len;
      end
    end
  end

`ifdef PKT_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Counts WAIT_FIN cycles; expiry lands TIMEOUT_CYC cycles after the LAUNCH cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wd_cnt <= '0;
    else if (fsm_q == L_LAUNCH) wd_cnt <= '0;
    else if (fsm_q == L_WAIT_FIN) wd_cnt <= wd_cnt + 16'd1;
  end

  assign expire = (fsm_q == L_WAIT_FIN) && !finish && (wd_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign expire = 1'b0 && (TIMEOUT_CYC > 0);
`endif

endmodule

// File: tb/tb_pkt_bank_scheduler.sv
// Directed bench for pkt_bank_scheduler: cycle tables for grant/commit/launch, plus a watchdog sequence.
module tb_pkt_bank_scheduler;

  localparam int NUM_BANKS   = 2;
  localparam int LEN_W       = 16;
  localparam int TIMEOUT_CYC = 16;
`ifdef PKT_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        rst, req, done;
    logic [15:0] len;
    logic        fin;
    logic        gnt, wbank, st, rbank;
    logic [15:0] lenbe;
    logic [2:0]  free;
    logic        eproto;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn, wr_req, wr_done, finish;
  logic [15:0] wr_len;
  logic        wr_gnt, start, err_proto, err_timeout;
  logic [0:0]  wr_bank, rd_bank;
  logic [15:0] length_be;
  logic [2:0]  banks_free;
  int          total = 0;
  int          bad = 0;
  vec_t        vecs[$];

  pkt_bank_scheduler #(
    .NUM_BANKS(NUM_BANKS), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_bank(wr_bank),
    .wr_done(wr_done), .wr_len(wr_len), .start(start), .rd_bank(rd_bank),
    .length_be(length_be), .finish(finish), .banks_free(banks_free),
    .err_proto(err_proto), .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;

  function automatic vec_t mk(input logic rst, req, done, input logic [15:0] len, input logic fin,
                              input logic gnt, wbank, st, rbank, input logic [15:0] lenbe,
                              input logic [2:0] free, input logic eproto);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done; v.len = len; v.fin = fin;
    v.gnt = gnt; v.wbank = wbank; v.st = st; v.rbank = rbank; v.lenbe = lenbe;
    v.free = free; v.eproto = eproto;
    return v;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic req, done, input logic [15:0] len, input logic fin);
    wr_req = req; wr_done = done; wr_len = len; finish = fin;
  endtask

  task automatic applyStimulus(input vec_t v);
    aresetn = !v.rst;
    drive(v.req, v.done, v.len, v.fin);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d wr_gnt", i), 32'(wr_gnt), 32'(v.gnt));
    checkOutput($sformatf("v%0d wr_bank", i), 32'(wr_bank), 32'(v.wbank));
    checkOutput($sformatf("v%0d start", i), 32'(start), 32'(v.st));
    checkOutput($sformatf("v%0d rd_bank", i), 32'(rd_bank), 32'(v.rbank));
    checkOutput($sformatf("v%0d length_be", i), 32'(length_be), 32'(v.lenbe));
    checkOutput($sformatf("v%0d banks_free", i), 32'(banks_free), 32'(v.free));
    checkOutput($sformatf("v%0d err_proto", i), 32'(err_proto), 32'(v.eproto));
    checkOutput($sformatf("v%0d err_timeout", i), 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;

    //          rst req dn len   fin  gnt wb st rb lenbe free ep
    // single frame: grant bank0, commit 1514 bytes, start two cycles after wr_done
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 0, 1, 1514, 0,  1, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 1, 0, 1514, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    1,  0, 0, 0, 0, 1514, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 0, 1514, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0,    0,  0, 0, 0, 0, 0,    2, 0));
    // ping-pong: A in bank0, B in bank1 while A drains, third request waits for A's finish
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 0, 1, 64,   0,  1, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 1, 128,  0,  1, 1, 1, 0, 64,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 1, 0, 0, 64,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0,    1,  0, 1, 0, 0, 64,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 1, 0, 0, 64,   1, 0));
    vecs.push_back(mk(0, 0, 1, 200,  0,  1, 0, 1, 1, 128,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    1,  0, 0, 0, 1, 128,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 1, 128,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 1, 0, 200,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    1,  0, 0, 0, 0, 200,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 0, 200,  2, 0));
    // zero-length commit frees the bank; stray wr_done and stray finish raise err_proto
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 0, 0, 0, 200,  2, 0));
    vecs.push_back(mk(0, 0, 1, 0,    0,  1, 1, 0, 0, 200,  1, 0));
    vecs.push_back(mk(0, 0, 1, 50,   0,  0, 1, 0, 0, 200,  2, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 1, 0, 0, 200,  2, 1));
    vecs.push_back(mk(0, 0, 0, 0,    1,  0, 1, 0, 0, 200,  2, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 1, 0, 0, 200,  2, 1));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 1, 0, 0, 200,  2, 0));
    // finish and wr_done in the same cycle; freed bank0 is re-granted immediately
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 1, 0, 0, 200,  2, 0));
    vecs.push_back(mk(0, 0, 1, 300,  0,  1, 0, 0, 0, 200,  1, 0));
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 0, 0, 0, 200,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  1, 1, 1, 0, 300,  0, 0));
    vecs.push_back(mk(0, 0, 1, 400,  1,  1, 1, 0, 0, 300,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 1, 0, 0, 300,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  1, 0, 1, 1, 400,  0, 0));
    // reset while draining with a grant held, then no start until a new grant+commit
    vecs.push_back(mk(1, 0, 0, 0,    0,  0, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 1, 0, 0,    0,  0, 0, 0, 0, 0,    2, 0));
    vecs.push_back(mk(0, 0, 1, 5,    0,  1, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 1, 0, 5,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    1,  0, 0, 0, 0, 5,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0,  0, 0, 0, 0, 5,    2, 0));

    aresetn = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checkVector(-1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    step();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge aclk);
      checkVector(i, vecs[i]);
      step();
    end

    // Backend never finishes: watchdog (if built in) frees the bank 16 cycles after LAUNCH.
    drive(1, 0, 0, 0);
    @(negedge aclk);
    step();
    drive(0, 1, 77, 0);
    @(negedge aclk);
    checkOutput("wd grant", 32'(wr_gnt), 32'd1);
    checkOutput("wd grant bank", 32'(wr_bank), 32'd1);
    step();
    drive(0, 0, 0, 0);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge aclk);
      if (start) found = 1'b1;
      else step();
    end
    checkOutput("wd launch seen", 32'(found), 32'd1);
    checkOutput("wd length_be", 32'(length_be), 32'd77);
    step();
    for (int k = 1; k <= 20; k++) begin
      @(negedge aclk);
      checkOutput($sformatf("wd err_timeout k=%0d", k), 32'(err_timeout), 32'(TO_EN && k == TIMEOUT_CYC));
      if (k == TIMEOUT_CYC + 1)
        checkOutput("wd banks_free after expiry", 32'(banks_free), TO_EN ? 32'd2 : 32'd1);
      step();
    end
    drive(0, 0, 0, 1);
    @(negedge aclk);
    step();
    drive(0, 0, 0, 0);
    @(negedge aclk);
    checkOutput("wd late finish err_proto", 32'(err_proto), 32'(TO_EN));
    checkOutput("wd final banks_free", 32'(banks_free), 32'd2);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
